// File: rtl/br_pkg.sv
// Shared types and constants for the branch-predictor update sequencer.
package br_pkg;

    localparam int unsigned DBITS       = 32;
    localparam int unsigned PHT_IDX_W   = 8;
    localparam int unsigned BHR_W       = 8;
    localparam int unsigned BTB_IDX_W   = 4;
    localparam int unsigned BTB_ENTRY_W = 59;
    localparam int unsigned CNT_W       = 2;

    localparam logic [CNT_W-1:0] PHT_INIT = 2'b10;

    typedef struct packed {
        logic [DBITS-1:0]     pc;
        logic                 taken;
        logic [DBITS-1:0]     target;
        logic [BHR_W-1:0]     bhr;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [CNT_W-1:0]     pht_cnt;
        logic                 pred_taken;
        logic                 pred_hit;
    } res_rec_t;

    localparam int unsigned REC_W = $bits(res_rec_t);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 2-bit saturating counter step toward the resolved direction
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/br_upd_fifo.sv
// Synchronous resolution-record FIFO with flush; DEPTH must be a power of two.
module br_upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count < CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rptr];

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/br_update_ctrl.sv
// Branch-predictor table write sequencer: init sweep, then one resolved-branch update per cycle.
// Optional statistics counters are built when BR_UPD_STATS_EN is defined.
module br_update_ctrl
    import br_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PHT_ENTRIES = 256,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_req,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic [7:0]  res_bhr,
    input  logic [7:0]  res_pht_idx,
    input  logic [1:0]  res_pht_cnt,
    input  logic        res_pred_taken,
    input  logic        res_pred_hit,
    output logic        init_done,
    output logic        bhr_we,
    output logic        pht_we,
    output logic        btb_we,
    output logic [7:0]  wr_bhr,
    output logic [7:0]  wr_pht_idx,
    output logic [1:0]  wr_pht_cnt,
    output logic [3:0]  wr_btb_idx,
    output logic [58:0] wr_btb_entry
`ifdef BR_UPD_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned IW = $clog2(PHT_ENTRIES);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [IW-1:0] sweep_idx;
    logic [IW-1:0] sw_idx;
    logic [CW-1:0] fifo_count;
    res_rec_t      in_rec;
    res_rec_t      head_rec;
    res_rec_t      drain_rec;
    logic          push;
    logic          bypass;
    logic          fifo_pop;
    logic          drain;

    assign in_rec = '{pc: res_pc, taken: res_taken, target: res_target, bhr: res_bhr,
                      pht_idx: res_pht_idx, pht_cnt: res_pht_cnt,
                      pred_taken: res_pred_taken, pred_hit: res_pred_hit};

    assign res_ready = !reset && (fifo_count < CW'(DEPTH));
    assign push      = res_valid && res_ready;

    // An empty FIFO in RUN forwards the incoming record straight to the write registers
    assign bypass    = (state == RUN) && (fifo_count == '0);
    assign fifo_pop  = (state == RUN) && !clear_req && (fifo_count != '0);
    assign drain     = (state == RUN) && !clear_req && ((fifo_count != '0) || push);
    assign drain_rec = (fifo_count != '0) ? head_rec : in_rec;
    assign sw_idx    = clear_req ? '0 : sweep_idx;

    br_upd_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear_req),
        .push  (push && !bypass),
        .pop   (fifo_pop),
        .wdata (in_rec),
        .rdata (head_rec),
        .count (fifo_count)
    );

    // FSM and registered write port; a clear issues sweep index 0 immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            sweep_idx    <= '0;
            init_done    <= 1'b0;
            bhr_we       <= 1'b0;
            pht_we       <= 1'b0;
            btb_we       <= 1'b0;
            wr_bhr       <= '0;
            wr_pht_idx   <= '0;
            wr_pht_cnt   <= '0;
            wr_btb_idx   <= '0;
            wr_btb_entry <= '0;
        end else begin
            bhr_we <= 1'b0;
            pht_we <= 1'b0;
            btb_we <= 1'b0;
            if (clear_req || state == INIT) begin
                init_done  <= 1'b0;
                pht_we     <= 1'b1;
                wr_pht_idx <= PHT_IDX_W'(sw_idx);
                wr_pht_cnt <= PHT_INIT;
                if (sw_idx == '0) begin
                    bhr_we <= 1'b1;
                    wr_bhr <= '0;
                end
                if (32'(sw_idx) < BTB_ENTRIES) begin
                    btb_we       <= 1'b1;
                    wr_btb_idx   <= BTB_IDX_W'(sw_idx);
                    wr_btb_entry <= '0;
                end
                if (sw_idx == IW'(PHT_ENTRIES - 1)) begin
                    state     <= RUN;
                    sweep_idx <= '0;
                end else begin
                    state     <= INIT;
                    sweep_idx <= sw_idx + IW'(1);
                end
            end else begin
                init_done <= 1'b1;
                if (drain) begin
                    pht_we       <= 1'b1;
                    wr_pht_idx   <= drain_rec.pht_idx;
                    wr_pht_cnt   <= sat_cnt(drain_rec.pht_cnt, drain_rec.taken);
                    bhr_we       <= 1'b1;
                    wr_bhr       <= {drain_rec.bhr[BHR_W-2:0], drain_rec.taken};
                    btb_we       <= drain_rec.taken;
                    wr_btb_idx   <= drain_rec.pc[5:2];
                    wr_btb_entry <= {drain_rec.pc[31:6], 1'b1, drain_rec.target};
                end
            end
        end
    end

`ifdef BR_UPD_STATS_EN
    logic mispred;
    logic unused_pc;

    assign mispred   = (drain_rec.taken != drain_rec.pred_taken) ||
                       (drain_rec.taken && !drain_rec.pred_hit);
    assign unused_pc = ^drain_rec.pc[1:0];

    // Saturating branch / mispredict counters
    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (drain) begin
            if (stat_branches != '1)          stat_branches <= stat_branches + 32'd1;
            if (mispred && stat_mispred != '1) stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`else
    logic unused_rec;
    assign unused_rec = ^{drain_rec.pc[1:0], drain_rec.pred_taken, drain_rec.pred_hit};
`endif

endmodule

// File: tb/tb_br_update_ctrl.sv
// Directed self-checking bench for br_update_ctrl (stat checks need BR_UPD_STATS_EN).
module tb_br_update_ctrl;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        reset, clear_req, res_valid, res_ready;
    logic [31:0] res_pc, res_target;
    logic        res_taken, res_pred_taken, res_pred_hit;
    logic [7:0]  res_bhr, res_pht_idx;
    logic [1:0]  res_pht_cnt;
    logic        init_done, bhr_we, pht_we, btb_we;
    logic [7:0]  wr_bhr, wr_pht_idx;
    logic [1:0]  wr_pht_cnt;
    logic [3:0]  wr_btb_idx;
    logic [58:0] wr_btb_entry;
`ifdef BR_UPD_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int tests = 0;
    int fails = 0;

    res_rec_t q [5];
    res_rec_t c [4];
    logic     tk [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic     pt [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic     ph [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    br_update_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .clear_req      (clear_req),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_bhr        (res_bhr),
        .res_pht_idx    (res_pht_idx),
        .res_pht_cnt    (res_pht_cnt),
        .res_pred_taken (res_pred_taken),
        .res_pred_hit   (res_pred_hit),
        .init_done      (init_done),
        .bhr_we         (bhr_we),
        .pht_we         (pht_we),
        .btb_we         (btb_we),
        .wr_bhr         (wr_bhr),
        .wr_pht_idx     (wr_pht_idx),
        .wr_pht_cnt     (wr_pht_cnt),
        .wr_btb_idx     (wr_btb_idx),
        .wr_btb_entry   (wr_btb_entry)
`ifdef BR_UPD_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input res_rec_t r, input logic v);
        res_valid      = v;
        res_pc         = r.pc;
        res_taken      = r.taken;
        res_target     = r.target;
        res_bhr        = r.bhr;
        res_pht_idx    = r.pht_idx;
        res_pht_cnt    = r.pht_cnt;
        res_pred_taken = r.pred_taken;
        res_pred_hit   = r.pred_hit;
    endtask

    task automatic sweep_check(input int k);
        check("sweep_pht_we",    64'(pht_we),     64'(1));
        check("sweep_pht_idx",   64'(wr_pht_idx), 64'(k));
        check("sweep_pht_cnt",   64'(wr_pht_cnt), 64'(2));
        check("sweep_btb_we",    64'(btb_we),     64'(k < 16));
        check("sweep_bhr_we",    64'(bhr_we),     64'(k == 0));
        check("sweep_init_done", 64'(init_done),  64'(0));
        if (k < 16) begin
            check("sweep_btb_idx",   64'(wr_btb_idx),   64'(k));
            check("sweep_btb_entry", 64'(wr_btb_entry), 64'(0));
        end
        if (k == 0) check("sweep_bhr", 64'(wr_bhr), 64'(0));
    endtask

    task automatic check_wr(input logic [7:0] idx, input logic [1:0] cnt, input logic [7:0] bhr,
                            input logic bwe, input logic [3:0] bidx, input logic [58:0] entry);
        check("upd_pht_we",  64'(pht_we),     64'(1));
        check("upd_pht_idx", 64'(wr_pht_idx), 64'(idx));
        check("upd_pht_cnt", 64'(wr_pht_cnt), 64'(cnt));
        check("upd_bhr_we",  64'(bhr_we),     64'(1));
        check("upd_bhr",     64'(wr_bhr),     64'(bhr));
        check("upd_btb_we",  64'(btb_we),     64'(bwe));
        if (bwe) begin
            check("upd_btb_idx",   64'(wr_btb_idx),   64'(bidx));
            check("upd_btb_entry", 64'(wr_btb_entry), 64'(entry));
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, 64'({pht_we, bhr_we, btb_we}), 64'(0));
    endtask

    initial begin
        c[0] = '{pc: 32'h1040, taken: 1'b1, target: 32'h2000, bhr: 8'h5A, pht_idx: 8'h33, pht_cnt: 2'd3, pred_taken: 1'b1, pred_hit: 1'b1};
        c[1] = '{pc: 32'h2004, taken: 1'b0, target: 32'h0,    bhr: 8'h01, pht_idx: 8'h10, pht_cnt: 2'd0, pred_taken: 1'b0, pred_hit: 1'b0};
        c[2] = '{pc: 32'h00F8, taken: 1'b1, target: 32'h44,   bhr: 8'h00, pht_idx: 8'h34, pht_cnt: 2'd1, pred_taken: 1'b1, pred_hit: 1'b1};
        c[3] = '{pc: 32'h0500, taken: 1'b0, target: 32'h0,    bhr: 8'h80, pht_idx: 8'h35, pht_cnt: 2'd2, pred_taken: 1'b0, pred_hit: 1'b1};
        q[0] = '{pc: 32'h100,      taken: 1'b1, target: 32'h200,      bhr: 8'h80, pht_idx: 8'h01, pht_cnt: 2'd0, pred_taken: 1'b1, pred_hit: 1'b1};
        q[1] = '{pc: 32'h108,      taken: 1'b0, target: 32'h0,        bhr: 8'h0F, pht_idx: 8'h02, pht_cnt: 2'd3, pred_taken: 1'b1, pred_hit: 1'b1};
        q[2] = '{pc: 32'h13C,      taken: 1'b1, target: 32'hDEADBEE0, bhr: 8'hFF, pht_idx: 8'h03, pht_cnt: 2'd2, pred_taken: 1'b0, pred_hit: 1'b0};
        q[3] = '{pc: 32'hFFFFFFC4, taken: 1'b0, target: 32'h0,        bhr: 8'h55, pht_idx: 8'hFF, pht_cnt: 2'd1, pred_taken: 1'b0, pred_hit: 1'b1};
        q[4] = '{pc: 32'h400,      taken: 1'b1, target: 32'h800,      bhr: 8'h00, pht_idx: 8'h44, pht_cnt: 2'd0, pred_taken: 1'b1, pred_hit: 1'b1};

        reset = 1'b1;
        clear_req = 1'b0;
        apply(q[4], 1'b0);
        tick;
        tick;
        check("rst_res_ready", 64'(res_ready),    64'(0));
        check("rst_init_done", 64'(init_done),    64'(0));
        check_idle("rst_strobes");
        check("rst_data", 64'({wr_bhr, wr_pht_idx, wr_pht_cnt, wr_btb_idx}), 64'(0));
        check("rst_entry", 64'(wr_btb_entry), 64'(0));
`ifdef BR_UPD_STATS_EN
        check("rst_stats", 64'({stat_branches, stat_mispred}), 64'(0));
`endif
        reset = 1'b0;

        // Initial sweep after reset
        tick;
        sweep_check(0);
        for (int k = 1; k < 256; k++) begin
            tick;
            sweep_check(k);
        end
        tick;
        check("init_done_rise", 64'(init_done), 64'(1));
        check_idle("idle_after_init");
        check("ready_after_init", 64'(res_ready), 64'(1));

        // Back-to-back updates through the empty FIFO
        apply(c[0], 1'b1); tick;
        check_wr(8'h33, 2'd3, 8'hB5, 1'b1, 4'h0, {26'h41, 1'b1, 32'h2000});
        apply(c[1], 1'b1); tick;
        check_wr(8'h10, 2'd0, 8'h02, 1'b0, 4'h0, 59'h0);
        apply(c[2], 1'b1); tick;
        check_wr(8'h34, 2'd2, 8'h01, 1'b1, 4'hE, {26'h3, 1'b1, 32'h44});
        apply(c[3], 1'b1); tick;
        check_wr(8'h35, 2'd1, 8'h00, 1'b0, 4'h0, 59'h0);
        res_valid = 1'b0;
        tick;
        check_idle("single_cycle_strobe");

        // Clear, then fill the FIFO during the sweep with 5 back-to-back pushes
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        sweep_check(0);
`ifdef BR_UPD_STATS_EN
        check("stats_cleared", 64'({stat_branches, stat_mispred}), 64'(0));
`endif
        for (int k = 1; k < 256; k++) begin
            if (k <= 5) begin
                check("init_push_ready", 64'(res_ready), 64'(k <= 4));
                apply(q[k-1], 1'b1);
            end else begin
                res_valid = 1'b0;
            end
            tick;
            sweep_check(k);
        end
        check("full_not_ready", 64'(res_ready), 64'(0));
        tick;
        check("init_done_2", 64'(init_done), 64'(1));
        check_wr(8'h01, 2'd1, 8'h01, 1'b1, 4'h0, {26'h4, 1'b1, 32'h200});
        tick;
        check_wr(8'h02, 2'd2, 8'h1E, 1'b0, 4'h0, 59'h0);
        tick;
        check_wr(8'h03, 2'd3, 8'hFF, 1'b1, 4'hF, {26'h4, 1'b1, 32'hDEADBEE0});
        tick;
        check_wr(8'hFF, 2'd0, 8'hAA, 1'b0, 4'h0, 59'h0);
        tick;
        check_idle("fifth_dropped");
        check("ready_after_drain", 64'(res_ready), 64'(1));
`ifdef BR_UPD_STATS_EN
        check("stats_4_2", 64'({stat_branches, stat_mispred}), {32'd4, 32'd2});
`endif

        // Clear with 3 records queued at the first RUN cycle, plus a same-cycle push
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        sweep_check(0);
        for (int k = 1; k < 256; k++) begin
            if (k <= 3) apply(q[k-1], 1'b1);
            else        res_valid = 1'b0;
            tick;
            sweep_check(k);
        end
        clear_req = 1'b1;
        apply(q[4], 1'b1);
        tick;
        clear_req = 1'b0;
        res_valid = 1'b0;
        sweep_check(0);
        check("ready_after_clear", 64'(res_ready), 64'(1));
`ifdef BR_UPD_STATS_EN
        check("stats_clear_run", 64'({stat_branches, stat_mispred}), 64'(0));
`endif
        for (int k = 1; k < 256; k++) begin
            tick;
            sweep_check(k);
        end
        tick;
        check("init_done_4", 64'(init_done), 64'(1));
        check_idle("no_drain_after_clear_a");
        tick;
        check_idle("no_drain_after_clear_b");

        // Ten streamed records, three of them mispredicted
        for (int k = 0; k < 10; k++) begin
            apply('{pc: 32'h3000 + 32'(4 * k), taken: tk[k], target: 32'h4000 + 32'(k),
                    bhr: 8'h00, pht_idx: 8'(8'h60 + k), pht_cnt: 2'd1,
                    pred_taken: pt[k], pred_hit: ph[k]}, 1'b1);
            tick;
            check_wr(8'(8'h60 + k), tk[k] ? 2'd2 : 2'd0, {7'b0, tk[k]}, tk[k], 4'(k),
                     {26'hC0, 1'b1, 32'h4000 + 32'(k)});
        end
        res_valid = 1'b0;
`ifdef BR_UPD_STATS_EN
        check("stats_10_3", 64'({stat_branches, stat_mispred}), {32'd10, 32'd3});
`endif
        tick;
        check_idle("stream_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
